pow_25519: RTL and testbench
============================

Name: pow_25519

Overview:
- Fixed-exponent modular exponentiation controller over GF(2^255-19).
- Default exponent is P-2, so the default build is the field inverter used for affine conversion in the Ed25519 point pipeline.
- Owns no multiplier. It sequences left-to-right square-and-multiply through one external mul_25519-style multiplier and feeds each multiplier result back as the next operand.
- A second instance with EXP=(P+3)/8 serves the point-decompression square root.

Parameters:
- EXP, 255'h7FFF...FFEB (P-2): exponent; constant at elaboration.
- EXP_MSB, 254: index of the highest set bit of EXP; must match EXP.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- a  in  255  base; must be < P
- res  out  255  a^EXP mod P; valid while done=1, held until the next done
- done  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after start is accepted until the cycle done is asserted
- mul_start  out  1  one-cycle pulse to the multiplier
- mul_a  out  255  multiplier operand A
- mul_b  out  255  multiplier operand B
- mul_res  in  255  multiplier result, reduced mod P
- mul_done  in  1  one-cycle multiplier completion pulse

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; done=0; busy=0; mul_start=0; res=0; mul_a=0; mul_b=0.
- Reset mid-operation abandons the run with no done pulse. The multiplier instance must be reset on the same reset event.
- States: IDLE, SQ_ISSUE, SQ_WAIT, ML_ISSUE, ML_WAIT.
- Internal registers: base (255 b), acc (255 b), idx (8 b).
- IDLE + start:
  - Latch base=a, acc=a, idx=EXP_MSB-1.
  - Go to SQ_ISSUE.
  - If EXP_MSB==0: res=a, done=1 next cycle, stay IDLE.
- SQ_ISSUE (1 cycle): mul_start=1, mul_a=mul_b=acc. Go to SQ_WAIT.
- SQ_WAIT: on mul_done, acc<=mul_res.
  - If EXP[idx]=1: go to ML_ISSUE.
  - Else if idx==0: finish.
  - Else idx<=idx-1 and go to SQ_ISSUE.
- ML_ISSUE (1 cycle): mul_start=1, mul_a=acc, mul_b=base. Go to ML_WAIT.
- ML_WAIT: on mul_done, acc<=mul_res.
  - If idx==0: finish.
  - Else idx<=idx-1 and go to SQ_ISSUE.
- Finish: at the same edge that captures the last result, res<=mul_res, done<=1 for exactly one cycle, busy<=0, state<=IDLE.
- mul_a and mul_b are held stable from the issue cycle until mul_done is seen.
- mul_start is never asserted while an operation is outstanding.
- start while busy is ignored; a and base are not re-latched.
- mul_done seen in IDLE or in an ISSUE state is ignored.
- start in the same cycle as the done pulse: the block is in IDLE, so start is accepted.
- Op count N = EXP_MSB + (popcount(EXP) - 1). For the default EXP, bits 2 and 4 are 0, so N = 254 squarings + 252 multiplies = 506.
- Latency: let L be the number of cycles from a mul_start cycle to its mul_done cycle. start sampled in cycle s gives done visible in cycle s+1+N*(L+1).
- For the team multiplier L=68, so the default build takes 1+506*69 = 34915 cycles.
- a=0 yields 0, with no special-casing.

Test Plan:
- a=1, default EXP, paired with the real multiplier -> done after exactly 34915 cycles; res=1; busy high throughout the run.
- a=2 -> res=0x3FFF...FFF7 ((P+1)/2); independently, res*2 mod P = 1.
- a=P-1 (0x7FFF...FFEC) -> res=P-1. a=0 -> res=0. Then 20 random a -> (res*a) mod P = 1, checked against a bench model.
- Count mul_start pulses per run -> 506. Operand sequence: (acc,acc) squares, and (acc,base) multiplies on every idx except 4 and 2. start pulsed mid-run -> ignored, result unchanged.
- Stub multiplier with L=3 and a spurious mul_done in IDLE -> no state change; done at s+1+506*4.
- rst=1 at cycle 10000 mid-run -> next cycle done=0, busy=0, mul_start=0, res=0. A fresh start with a=2 then yields the correct result.

Source files
------------

// File: rtl/pow_25519.sv
// Fixed-exponent modular exponentiation over GF(2^255-19).
// Left-to-right square-and-multiply through one external multiplier.
`timescale 1ns/1ps
module pow_25519 #(
  parameter logic [254:0] EXP = ~255'd20,
  parameter int EXP_MSB = 254
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [254:0] a,
  output logic [254:0] res,
  output logic         done,
  output logic         busy,
  output logic         mul_start,
  output logic [254:0] mul_a,
  output logic [254:0] mul_b,
  input  logic [254:0] mul_res,
  input  logic         mul_done
);

  typedef enum logic [2:0] {
    IDLE,
    SQ_ISSUE,
    SQ_WAIT,
    ML_ISSUE,
    ML_WAIT
  } state_t;

  localparam logic [7:0] IDX_TOP = 8'(EXP_MSB - 1);

  state_t       state;
  logic [254:0] base;
  logic [254:0] acc;
  logic [7:0]   idx;

  // Operand A is always the running accumulator.
  assign mul_a = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      acc       <= '0;
      idx       <= '0;
      res       <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_b     <= '0;
    end else begin
      done      <= 1'b0;
      mul_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            base <= a;
            acc  <= a;
            idx  <= IDX_TOP;
            if (EXP_MSB == 0) begin
              res  <= a;
              done <= 1'b1;
            end else begin
              busy      <= 1'b1;
              mul_start <= 1'b1;
              mul_b     <= a;
              state     <= SQ_ISSUE;
            end
          end
        end
        SQ_ISSUE: state <= SQ_WAIT;
        SQ_WAIT: begin
          if (mul_done) begin
            acc <= mul_res;
            if (EXP[idx]) begin
              mul_start <= 1'b1;
              mul_b     <= base;
              state     <= ML_ISSUE;
            end else if (idx == 8'd0) begin
              res   <= mul_res;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idx       <= idx - 8'd1;
              mul_start <= 1'b1;
              mul_b     <= mul_res;
              state     <= SQ_ISSUE;
            end
          end
        end
        ML_ISSUE: state <= ML_WAIT;
        ML_WAIT: begin
          if (mul_done) begin
            acc <= mul_res;
            if (idx == 8'd0) begin
              res   <= mul_res;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idx       <= idx - 8'd1;
              mul_start <= 1'b1;
              mul_b     <= mul_res;
              state     <= SQ_ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pow_25519.sv
// Bench for pow_25519: behavioural multiplier with settable latency,
// directed vector table plus hand-written reset and spurious-done cases.
`timescale 1ns/1ps
module tb_pow_25519;

  localparam logic [254:0] P    = ~255'd18;
  localparam logic [254:0] PM2  = ~255'd20;
  localparam logic [254:0] HALF = (~255'd0 >> 1) - 255'd8;
  localparam int NOPS = 506;
  localparam int NMUL = 252;

  typedef struct {
    logic [254:0] a;
    int           lat;
    logic [254:0] res;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [254:0] a = '0;
  logic [254:0] res;
  logic         done;
  logic         busy;
  logic         mul_start;
  logic [254:0] mul_a;
  logic [254:0] mul_b;
  logic [254:0] mul_res = '0;
  logic         mul_done;

  logic md_q = 1'b0;
  logic spur = 1'b0;
  logic mbusy = 1'b0;
  int   mcnt = 0;
  int   lat = 1;

  int n_cmp = 0;
  int n_bad = 0;

  assign mul_done = md_q | spur;

  always #5 clk = ~clk;

  pow_25519 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .res      (res),
    .done     (done),
    .busy     (busy),
    .mul_start(mul_start),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_res  (mul_res),
    .mul_done (mul_done)
  );

  function automatic logic [254:0] mulmod(input logic [254:0] x,
                                          input logic [254:0] y);
    logic [509:0] pr;
    logic [509:0] m;
    pr = {255'd0, x} * {255'd0, y};
    m  = pr % {255'd0, P};
    return m[254:0];
  endfunction

  // Multiplier model: mul_done arrives lat cycles after the mul_start cycle.
  always @(posedge clk) begin
    md_q <= 1'b0;
    if (rst) begin
      mbusy <= 1'b0;
    end else if (mul_start && !mbusy) begin
      mul_res <= mulmod(mul_a, mul_b);
      if (lat <= 1) begin
        md_q <= 1'b1;
      end else begin
        mbusy <= 1'b1;
        mcnt  <= lat - 1;
      end
    end else if (mbusy) begin
      if (mcnt == 1) begin
        md_q  <= 1'b1;
        mbusy <= 1'b0;
      end
      mcnt <= mcnt - 1;
    end
  end

  task automatic chk(input string nm, input logic [254:0] act,
                     input logic [254:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_pow(input logic [254:0] av, input int l,
                         input int mid_at, input int abort_at,
                         output logic [254:0] r, output int n,
                         output int ops, output int muls,
                         output int operr, output int berr,
                         output bit got);
    logic [254:0] macc;
    logic [254:0] exa;
    logic [254:0] exb;
    int midx;
    bit mph;
    int limit;
    lat = l;
    limit = 1 + NOPS * (l + 1) + 50;
    @(negedge clk);
    a = av;
    start = 1'b1;
    macc = av;
    midx = 253;
    mph = 1'b0;
    ops = 0;
    muls = 0;
    operr = 0;
    berr = 0;
    got = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < limit) begin
      if (done) begin
        got = 1'b1;
        if (busy) berr++;
        break;
      end
      if (n == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_done", 255'(done), 255'd0);
        chk("abort_busy", 255'(busy), 255'd0);
        chk("abort_mstart", 255'(mul_start), 255'd0);
        chk("abort_res", res, 255'd0);
        rst = 1'b0;
        r = res;
        return;
      end
      if (!busy) berr++;
      if (mul_start) begin
        if (mbusy) operr++;
        exa = macc;
        exb = mph ? av : macc;
        if (mul_a !== exa || mul_b !== exb) operr++;
        ops++;
        if (mph) muls++;
        macc = mulmod(exa, exb);
        if (!mph && PM2[midx]) begin
          mph = 1'b1;
        end else begin
          mph = 1'b0;
          midx--;
        end
      end
      if (n == mid_at) begin
        start = 1'b1;
        a = av ^ 255'h5a5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    r = res;
  endtask

  initial begin
    vec_t tbl [4];
    logic [254:0] rr [4];
    logic [254:0] r;
    logic [254:0] av;
    logic [255:0] t;
    int n;
    int ops;
    int muls;
    int operr;
    int berr;
    bit got;

    tbl[0].a = 255'd1;         tbl[0].lat = 68; tbl[0].res = 255'd1;
    tbl[1].a = 255'd2;         tbl[1].lat = 1;  tbl[1].res = HALF;
    tbl[2].a = P - 255'd1;     tbl[2].lat = 1;  tbl[2].res = P - 255'd1;
    tbl[3].a = 255'd0;         tbl[3].lat = 1;  tbl[3].res = 255'd0;

    repeat (3) @(negedge clk);
    chk("rst_done", 255'(done), 255'd0);
    chk("rst_busy", 255'(busy), 255'd0);
    chk("rst_mstart", 255'(mul_start), 255'd0);
    chk("rst_res", res, 255'd0);
    chk("rst_mula", mul_a, 255'd0);
    chk("rst_mulb", mul_b, 255'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_pow(tbl[i].a, tbl[i].lat, (i == 1) ? 100 : 0, 0,
              r, n, ops, muls, operr, berr, got);
      rr[i] = r;
      chk($sformatf("v%0d_done", i), 255'(got), 255'd1);
      chk($sformatf("v%0d_res", i), r, tbl[i].res);
      chk($sformatf("v%0d_cycles", i), 255'(n),
          255'(1 + NOPS * (tbl[i].lat + 1)));
      chk($sformatf("v%0d_ops", i), 255'(ops), 255'(NOPS));
      chk($sformatf("v%0d_muls", i), 255'(muls), 255'(NMUL));
      chk($sformatf("v%0d_operr", i), 255'(operr), 255'd0);
      chk($sformatf("v%0d_busy", i), 255'(berr), 255'd0);
    end
    chk("inv2_times2", mulmod(rr[1], 255'd2), 255'd1);
    chk("a1_cycles_abs", 255'(1 + NOPS * 69), 255'd34915);

    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("spur_busy", 255'(busy), 255'd0);
    chk("spur_mstart", 255'(mul_start), 255'd0);
    chk("spur_done", 255'(done), 255'd0);
    chk("spur_res_held", res, rr[3]);

    run_pow(255'd5, 3, 0, 0, r, n, ops, muls, operr, berr, got);
    chk("l3_done", 255'(got), 255'd1);
    chk("l3_cycles", 255'(n), 255'd2025);
    chk("l3_inv", mulmod(r, 255'd5), 255'd1);
    chk("l3_operr", 255'(operr), 255'd0);

    for (int k = 0; k < 20; k++) begin
      for (int w = 0; w < 8; w++) t[w*32 +: 32] = $urandom;
      av = {1'b0, t[253:0]};
      if (av == '0) av = 255'd1;
      run_pow(av, 1, 0, 0, r, n, ops, muls, operr, berr, got);
      chk($sformatf("rnd%0d_inv", k), mulmod(r, av), 255'd1);
      chk($sformatf("rnd%0d_operr", k), 255'(operr), 255'd0);
    end

    run_pow(255'd7, 68, 0, 10000, r, n, ops, muls, operr, berr, got);
    chk("abort_nodone", 255'(got), 255'd0);
    run_pow(255'd2, 1, 0, 0, r, n, ops, muls, operr, berr, got);
    chk("post_abort_done", 255'(got), 255'd1);
    chk("post_abort_res", r, HALF);
    chk("post_abort_cycles", 255'(n), 255'(1 + NOPS * 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
